// File: rtl/pulse_dly_calendar.sv
`default_nettype none
// ============================================================================
// Module      : pulse_dly_calendar
// Description : Multi-channel pulse delay with payload; each pulse carries its
//               own delay into a per-channel calendar shift register.
//               Optional macro PULSE_DLY_COLL_CNT_EN adds saturating drop counters.
// Revision    : 1.0  initial release
// ============================================================================
module pulse_dly_calendar #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_DLY = 7,
  parameter int DLY_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          din_vld,
  input  logic [NUM_CH*DATA_W-1:0]   din_data,
  input  logic [NUM_CH*DLY_W-1:0]    sel,
  output logic [NUM_CH-1:0]          dout_vld,
  output logic [NUM_CH*DATA_W-1:0]   dout_data,
  output logic [NUM_CH-1:0]          coll,
  output logic [NUM_CH*CNT_W-1:0]    coll_cnt
);

  localparam logic [DLY_W-1:0] C_MAX_DLY = DLY_W'(MAX_DLY);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [MAX_DLY-1:0]        r_vld;
    logic [MAX_DLY*DATA_W-1:0] r_data;
    logic                      r_coll;
    logic [MAX_DLY:0]          w_vld_ext;
    logic [(MAX_DLY+1)*DATA_W-1:0] w_data_ext;
    logic [MAX_DLY-1:0]        w_vld_nxt;
    logic [MAX_DLY*DATA_W-1:0] w_data_nxt;
    logic [DLY_W-1:0]          w_sel;
    logic [DLY_W-1:0]          w_dly;
    logic [DATA_W-1:0]         w_din;
    logic                      w_drop;
    logic                      w_bypass;

    assign w_sel = sel[c*DLY_W +: DLY_W];
    assign w_din = din_data[c*DATA_W +: DATA_W];
    assign w_dly = (w_sel > C_MAX_DLY) ? C_MAX_DLY : w_sel;

    // Padding one empty slot above the top lets the shift be a plain slice.
    assign w_vld_ext  = {1'b0, r_vld};
    assign w_data_ext = {{DATA_W{1'b0}}, r_data};

    always_comb begin
      w_vld_nxt  = w_vld_ext[MAX_DLY:1];
      w_data_nxt = w_data_ext[(MAX_DLY+1)*DATA_W-1:DATA_W];
      w_drop     = 1'b0;
      w_bypass   = 1'b0;
      if (din_vld[c]) begin
        if (w_dly == '0) begin
          if (r_vld[0]) w_drop = 1'b1;
          else          w_bypass = 1'b1;
        end else begin
          for (int i = 0; i < MAX_DLY; i++) begin
            if (w_dly == DLY_W'(i + 1)) begin
              // Already scheduled pulse keeps the slot; newcomer is dropped.
              if (w_vld_nxt[i]) begin
                w_drop = 1'b1;
              end else begin
                w_vld_nxt[i]                    = 1'b1;
                w_data_nxt[i*DATA_W +: DATA_W] = w_din;
              end
            end
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= '0;
        r_data <= '0;
        r_coll <= 1'b0;
      end else if (flush) begin
        r_vld  <= '0;
        r_data <= '0;
        r_coll <= 1'b0;
      end else begin
        r_vld  <= w_vld_nxt;
        r_data <= w_data_nxt;
        r_coll <= w_drop;
      end
    end

    assign dout_vld[c] = ~flush & (r_vld[0] | w_bypass);
    assign dout_data[c*DATA_W +: DATA_W] = flush    ? '0 :
                                           r_vld[0] ? r_data[DATA_W-1:0] :
                                           w_bypass ? w_din : '0;
    assign coll[c] = r_coll;

`ifdef PULSE_DLY_COLL_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts in step with coll so both read consistently in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (w_drop && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign coll_cnt[c*CNT_W +: CNT_W] = r_cnt;
`else
    assign coll_cnt[c*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_dly_calendar.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_dly_calendar
// Description : Directed self-checking bench for pulse_dly_calendar (DLY_W=4 so
//               out-of-range sel values reach the clamp).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_dly_calendar;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 8;
  localparam int MAX_DLY = 7;
  localparam int DLY_W   = 4;
  localparam int CNT_W   = 8;
`ifdef PULSE_DLY_COLL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_CH-1:0]         din_vld;
  logic [NUM_CH*DATA_W-1:0]  din_data;
  logic [NUM_CH*DLY_W-1:0]   sel;
  logic [NUM_CH-1:0]         dout_vld;
  logic [NUM_CH*DATA_W-1:0]  dout_data;
  logic [NUM_CH-1:0]         coll;
  logic [NUM_CH*CNT_W-1:0]   coll_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_coll = 0;

  pulse_dly_calendar #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .din_vld(din_vld), .din_data(din_data), .sel(sel),
    .dout_vld(dout_vld), .dout_data(dout_data), .coll(coll), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic put(input int ch, input logic [7:0] data, input logic [3:0] s);
    din_vld[ch]            = 1'b1;
    din_data[ch*DATA_W +: DATA_W] = data;
    sel[ch*DLY_W +: DLY_W] = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    din_vld = '0;
  endtask

  function automatic logic [7:0] dat(input int ch);
    return dout_data[ch*DATA_W +: DATA_W];
  endfunction

  function automatic logic [7:0] cnt(input int ch);
    return coll_cnt[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; din_vld = '0; din_data = '0; sel = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld",  dout_vld,  0);
    chk("rst_data", dout_data, 0);
    chk("rst_coll", coll,      0);
    chk("rst_cnt",  coll_cnt,  0);
    @(posedge clk); #1; rst = 1'b0;
    tick();

    // Basic delay of 3 on ch0.
    put(0, 8'hA5, 4'd3);
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("t1_vld",  dout_vld,  (k == 3) ? 32'h1 : 32'h0);
      chk("t1_data", dout_data, (k == 3) ? 32'hA5 : 32'h0);
      chk("t1_coll", coll, 0);
      tick();
    end

    // Zero-delay bypass on ch1.
    put(1, 8'h3C, 4'd0);
    #2;
    chk("t2_vld",  dout_vld,  32'h2);
    chk("t2_data", dout_data, 32'h3C00);
    tick(); #2;
    chk("t2_after", dout_vld, 0);

    // Collision on ch2: older pulse wins.
    put(2, 8'h11, 4'd3); #2; tick();
    put(2, 8'h22, 4'd2); #2;
    chk("t3_coll_c1", coll, 0);
    tick(); #2;
    chk("t3_coll", coll, 32'h4);
    chk("t3_cnt",  cnt(2), CNT_EN ? 32'd1 : 32'd0);
    tick(); #2;
    chk("t3_vld",  dout_vld, 32'h4);
    chk("t3_data", dat(2), 32'h11);
    chk("t3_coll_c3", coll, 0);
    for (int k = 4; k < 7; k++) begin
      tick(); #2;
      chk("t3_tail", dout_vld, 0);
    end
    tick();

    // Reorder on ch3: later short pulse exits first.
    for (int k = 0; k < 7; k++) begin
      if (k == 0) put(3, 8'h55, 4'd5);
      if (k == 1) put(3, 8'h66, 4'd1);
      #2;
      chk("t4_vld",  dout_vld, (k == 2 || k == 5) ? 32'h8 : 32'h0);
      chk("t4_data", dat(3), (k == 2) ? 32'h66 : (k == 5) ? 32'h55 : 32'h0);
      chk("t4_coll", coll, 0);
      tick();
    end

    // Back-to-back equal delay on ch0.
    for (int k = 0; k < 6; k++) begin
      if (k < 3) put(0, 8'(k + 1), 4'd2);
      #2;
      chk("b2b_vld",  dout_vld[0], (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
      chk("b2b_data", dat(0), (k >= 2 && k <= 4) ? 32'(k - 1) : 32'h0);
      chk("b2b_coll", coll, 0);
      tick();
    end

    // Zero-delay collides with an occupied head slot on ch3.
    put(3, 8'h10, 4'd1); #2; tick();
    put(3, 8'h20, 4'd0); #2;
    chk("z_vld",  dout_vld, 32'h8);
    chk("z_data", dat(3), 32'h10);
    tick(); #2;
    chk("z_coll", coll, 32'h8);
    chk("z_vld2", dout_vld, 0);
    tick();

    // Async reset mid-flight, with a pending coll on ch1.
    put(0, 8'h77, 4'd7); tick();
    put(1, 8'h01, 4'd2); tick();
    put(1, 8'h02, 4'd1); tick();
    chk("t5_coll_pre", coll, 32'h2);
    rst = 1'b1; #1;
    chk("t5_rst_vld",  dout_vld,  0);
    chk("t5_rst_data", dout_data, 0);
    chk("t5_rst_coll", coll,      0);
    chk("t5_rst_cnt",  coll_cnt,  0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      #2;
      chk("t5_quiet", dout_vld, 0);
      chk("t5_coll",  coll, 0);
      tick();
    end

    // Flush cancels a scheduled pulse and swallows a concurrent input.
    put(0, 8'h99, 4'd4); tick();
    tick();
    flush = 1'b1;
    put(1, 8'h5A, 4'd0); #2;
    chk("fl_vld",  dout_vld, 0);
    chk("fl_data", dout_data, 0);
    tick(); flush = 1'b0;
    for (int k = 3; k < 7; k++) begin
      #2;
      chk("fl_quiet", dout_vld, 0);
      chk("fl_coll",  coll, 0);
      tick();
    end

    // Clamp: sel=15 behaves as 7.
    put(2, 8'hC3, 4'd15);
    for (int k = 0; k < 9; k++) begin
      #2;
      chk("cl_vld",  dout_vld, (k == 7) ? 32'h4 : 32'h0);
      chk("cl_data", dat(2), (k == 7) ? 32'hC3 : 32'h0);
      tick();
    end

    // 300 forced collisions on ch1.
    for (int n = 0; n < 300; n++) begin
      put(1, 8'(n), 4'd2); #2;
      if (coll[1]) n_coll++;
      tick();
      put(1, 8'hEE, 4'd1); #2;
      if (coll[1]) n_coll++;
      tick();
    end
    #2;
    if (coll[1]) n_coll++;
    chk("sat_ncoll", n_coll, 300);
    chk("sat_cnt", cnt(1), CNT_EN ? 32'd255 : 32'd0);
    tick();
    flush = 1'b1; #2;
    tick(); flush = 1'b0; #2;
    chk("sat_flush_cnt", coll_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
